seq_divider32: RTL and testbench

- Multi-cycle integer divider for the 32-bit arithmetic datapath. It is the inverse companion of the ripple add/sub unit: division by repeated shift-and-subtract.
- Accepts a signed or unsigned dividend/divisor pair on a start pulse and iterates one restoring step per clock.
- Returns quotient, remainder and exception flags with a done pulse.
- Sits beside the add/sub unit, in front of the result writeback.

---
 rtl/div_pkg.sv | 8 +
 rtl/seq_divider32_div_step.sv | 15 +
 rtl/seq_divider32.sv | 87 ++++++++
 tb/tb_seq_divider32.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
package div_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int CNT_W = $clog2(DEF_WIDTH);
    localparam logic [DEF_WIDTH-1:0] INT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};
    localparam logic [DEF_WIDTH-1:0] ALL_ONES = '1;
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;
endpackage

// File: rtl/seq_divider32_div_step.sv
// div_step: one restoring shift-and-subtract step on magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_out
);
    logic [WIDTH:0] trial;
    assign trial    = {rem, q_in} - {1'b0, dvs};
    assign q_out    = ~trial[WIDTH];
    assign rem_next = trial[WIDTH] ? {rem[WIDTH-2:0], q_in} : trial[WIDTH-1:0];
endmodule

// File: rtl/seq_divider32.sv
// seq_divider32: signed/unsigned multi-cycle divider, one restoring step per clock.
module seq_divider32
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic sop, neg_q, neg_r, q_bit;
    logic [WIDTH-1:0] dvd, dvs, q_r, r_r, d_abs, r_nx;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(r_r), .q_in(q_r[WIDTH-1]), .dvs(d_abs), .rem_next(r_nx), .q_out(q_bit)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // Divide-by-zero also passes through FIXUP so its result lands two edges after start.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? PREP : IDLE;
            PREP:    state_nx = (dvs == '0) ? FIXUP : ITER;
            ITER:    state_nx = (cnt == CW'(WIDTH-1)) ? FIXUP : ITER;
            FIXUP:   state_nx = DONE;
            DONE:    state_nx = start ? PREP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = ~ready;
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sop, neg_q, neg_r, cnt, dvd, dvs, q_r, r_r, d_abs} <= '0;
            {quotient, remainder, div_by_zero, overflow} <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    sop <= signed_op;
                    dvd <= dividend;
                    dvs <= divisor;
                end
                PREP: begin
                    q_r   <= (sop && dvd[WIDTH-1]) ? -dvd : dvd;
                    d_abs <= (sop && dvs[WIDTH-1]) ? -dvs : dvs;
                    neg_q <= sop && (dvd[WIDTH-1] ^ dvs[WIDTH-1]);
                    neg_r <= sop && dvd[WIDTH-1];
                    r_r   <= '0;
                    cnt   <= '0;
                end
                ITER: begin
                    q_r <= {q_r[WIDTH-2:0], q_bit};
                    r_r <= r_nx;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    quotient    <= (dvs == '0) ? '1 : (neg_q ? -q_r : q_r);
                    remainder   <= (dvs == '0) ? dvd : (neg_r ? -r_r : r_r);
                    div_by_zero <= (dvs == '0);
                    overflow    <= sop && (dvd == MIN_V) && (dvs == '1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: randomized scoreboard bench for seq_divider32 against an arithmetic model.
module tb_seq_divider32;
    logic clk = 0, rst_n = 0, start = 0, signed_op = 0;
    logic [31:0] dividend = 0, divisor = 0;
    logic ready, busy, done, div_by_zero, overflow;
    logic [31:0] quotient, remainder;
    int cyc = 0, total = 0, passed = 0;

    typedef struct {
        logic [31:0] q, r;
        logic dbz, ovf;
        int due;
    } exp_t;
    exp_t sb[$];

    seq_divider32 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .ready(ready), .busy(busy),
        .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain 64-bit truncating division; the divider's corner cases are stated directly.
    function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b, input int e);
        exp_t x;
        longint sa, sd;
        x.due = e + ((b == 0) ? 2 : 34);
        if (b == 0) begin
            x.q = 32'hFFFF_FFFF; x.r = a; x.dbz = 1; x.ovf = 0;
            return x;
        end
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sd = s ? longint'($signed(b)) : longint'({32'b0, b});
        x.q = 32'(sa / sd);
        x.r = 32'(sa % sd);
        x.dbz = 0;
        x.ovf = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return x;
    endfunction

    task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        start = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("issue_wait_ready", {31'b0, ready}, 32'd1);
        signed_op = s; dividend = a; divisor = b; start = 1;
        sb.push_back(model(s, a, b, cyc + 1));
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                exp_t x;
                x = sb.pop_front();
                chk("quotient", quotient, x.q);
                chk("remainder", remainder, x.r);
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, x.dbz});
                chk("overflow", {31'b0, overflow}, {31'b0, x.ovf});
                chk("latency", 32'(cyc), 32'(x.due));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        rst_n = 1;
        issue(0, 32'd100, 32'd7);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            start = 0;
            chk("busy_ready_low", {31'b0, ready}, 32'd0);
        end
        issue(0, 32'hFFFF_FFFF, 32'd1);
        issue(1, 32'hFFFF_FFF9, 32'd2);
        repeat (6) @(negedge clk);
        start = 1; signed_op = 0; dividend = 32'd123; divisor = 32'd0;
        @(negedge clk);
        start = 0;
        issue(1, 32'd7, 32'hFFFF_FFFE);
        issue(0, 32'd55, 32'd0);
        issue(1, 32'd55, 32'd0);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1, 32'h8000_0000, 32'd1);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            int m;
            a = $urandom;
            m = $urandom_range(0, 7);
            b = (m == 0) ? 32'd0 : (m == 1) ? 32'hFFFF_FFFF : (m == 2) ? 32'($urandom_range(1, 15)) : $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            issue(1'($urandom_range(0, 1)), a, b);
        end
        issue(0, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        start = 0;
        #2 rst_n = 0;
        #1;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_flags", {30'b0, div_by_zero, overflow}, 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1;
        issue(0, 32'd100, 32'd7);
        begin
            int n = 0;
            @(negedge clk);
            start = 0;
            while (sb.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("drain", 32'(sb.size()), 32'd0);
        end
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
